// File: rtl/gs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gs_pkg
// Description : Shared types and width-dependent constants for the
//               Goldschmidt divide / square-root engine.
// Revision    : 1.0 - initial release
// ============================================================================
package gs_pkg;

    typedef enum logic {
        GS_DIV  = 1'b0,
        GS_SQRT = 1'b1
    } gs_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_N = 3'd1,
        ST_SQ_K  = 3'd2,
        ST_MUL_D = 3'd3,
        ST_REM   = 3'd4,
        ST_FIN   = 3'd5
    } gs_state_t;

    typedef enum logic [1:0] {
        A_N = 2'd0,
        A_D = 2'd1,
        A_K = 2'd2
    } gs_sel_a_t;

    typedef enum logic [1:0] {
        B_K   = 2'd0,
        B_T   = 2'd1,
        B_DEN = 2'd2,
        B_N   = 2'd3
    } gs_sel_b_t;

    // (2 + sqrt(2)) / 4 as a 64-bit binary fraction.
    localparam logic [63:0] C_K0_SQRT_FRAC64 = 64'hDA82_7999_FCEF_3242;

    function automatic logic [63:0] gs_k0_div(input int width);
        return 64'd3 << (width - 4);
    endfunction

    function automatic logic [63:0] gs_two(input int width);
        return 64'd2 << (width - 2);
    endfunction

    function automatic logic [63:0] gs_three(input int width);
        return 64'd3 << (width - 2);
    endfunction

    // Keep width-2 fraction bits, rounding to nearest on the first dropped bit.
    function automatic logic [63:0] gs_k0_sqrt(input int width);
        int sh;
        sh = 66 - width;
        return (C_K0_SQRT_FRAC64 >> sh) + ((C_K0_SQRT_FRAC64 >> (sh - 1)) & 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/goldschmidt_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : goldschmidt_unit_if
// Description : Start/done operation interface of the Goldschmidt engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface goldschmidt_unit_if #(
    parameter int WIDTH = 30
);
    import gs_pkg::*;

    logic             start;
    gs_op_t           op;
    logic [WIDTH-1:0] numerator;
    logic [WIDTH-1:0] denominator;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic             rem_sign;
    logic             err;

    modport master (
        output start, op, numerator, denominator,
        input  ready, done, quotient, rem_sign, err
    );

    modport slave (
        input  start, op, numerator, denominator,
        output ready, done, quotient, rem_sign, err
    );

endinterface
`default_nettype wire

// File: rtl/gs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gs_ctrl
// Description : Sequencer for the shared multiplier: state machine, iteration
//               counter, operand selects and register enables.
// Revision    : 1.0 - initial release
// ============================================================================
module gs_ctrl
    import gs_pkg::*;
#(
    parameter int ITERS = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      start,
    input  logic      range_ok,
    input  gs_op_t    op_cap,
    output logic      ready,
    output logic      load,
    output logic      err_set,
    output logic      n_en,
    output logic      d_en,
    output logic      k_en,
    output logic      t_en,
    output logic      rem_en,
    output gs_sel_a_t sel_a,
    output gs_sel_b_t sel_b
);

    localparam logic [3:0] ITER_LAST = 4'(ITERS - 1);

    gs_state_t  r_state;
    gs_state_t  w_state_next;
    logic [3:0] r_iter;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_iter  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (load) begin
                r_iter <= 4'd0;
            end else if (r_state == ST_MUL_D) begin
                r_iter <= r_iter + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        load         = 1'b0;
        err_set      = 1'b0;
        n_en         = 1'b0;
        d_en         = 1'b0;
        k_en         = 1'b0;
        t_en         = 1'b0;
        rem_en       = 1'b0;
        sel_a        = A_N;
        sel_b        = B_K;
        case (r_state)
            // FIN behaves like IDLE so a new operation can start without a gap.
            ST_IDLE, ST_FIN: begin
                ready        = 1'b1;
                w_state_next = ST_IDLE;
                if (start) begin
                    if (range_ok) begin
                        load         = 1'b1;
                        w_state_next = ST_MUL_N;
                    end else begin
                        err_set      = 1'b1;
                        w_state_next = ST_FIN;
                    end
                end
            end
            ST_MUL_N: begin
                n_en         = 1'b1;
                w_state_next = (op_cap == GS_SQRT) ? ST_SQ_K : ST_MUL_D;
            end
            ST_SQ_K: begin
                sel_a        = A_K;
                t_en         = 1'b1;
                w_state_next = ST_MUL_D;
            end
            ST_MUL_D: begin
                sel_a        = A_D;
                sel_b        = (op_cap == GS_SQRT) ? B_T : B_K;
                d_en         = 1'b1;
                k_en         = 1'b1;
                w_state_next = (r_iter == ITER_LAST) ? ST_REM : ST_MUL_N;
            end
            ST_REM: begin
                sel_b        = (op_cap == GS_SQRT) ? B_N : B_DEN;
                rem_en       = 1'b1;
                w_state_next = ST_FIN;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/goldschmidt_unit.sv
`default_nettype none
// ============================================================================
// Module      : goldschmidt_unit
// Description : Goldschmidt divide / square-root datapath around one shared
//               WIDTH x WIDTH multiplier, sequenced by gs_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module goldschmidt_unit
    import gs_pkg::*;
#(
    parameter int WIDTH = 30,
    parameter int ITERS = 4
) (
    input  logic               clk,
    input  logic               reset,
    goldschmidt_unit_if.slave  bus
);

    localparam logic [WIDTH-1:0] K0_DIV  = WIDTH'(gs_k0_div(WIDTH));
    localparam logic [WIDTH-1:0] K0_SQRT = WIDTH'(gs_k0_sqrt(WIDTH));
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(gs_two(WIDTH));
    localparam logic [WIDTH-1:0] THREE   = WIDTH'(gs_three(WIDTH));

    logic [WIDTH-1:0]   r_num, r_den, r_n, r_d, r_k, r_t, r_quotient;
    gs_op_t             r_op;
    logic               r_done, r_rem_sign, r_err;

    logic               w_range_ok, w_ready, w_load, w_err_set;
    logic               w_n_en, w_d_en, w_k_en, w_t_en, w_rem_en;
    gs_sel_a_t          w_sel_a;
    gs_sel_b_t          w_sel_b;
    logic [WIDTH-1:0]   w_a, w_b, w_res, w_res_raw, w_k_next, w_sqrt_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [1:0]         w_prod_top;
    logic [WIDTH-3:0]   w_prod_unused;

    assign w_range_ok = (bus.numerator[WIDTH-1 -: 2] == 2'b01) &&
                        ((bus.op == GS_SQRT) || (bus.denominator[WIDTH-1 -: 2] == 2'b01));

    gs_ctrl #(
        .ITERS (ITERS)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (bus.start),
        .range_ok (w_range_ok),
        .op_cap   (r_op),
        .ready    (w_ready),
        .load     (w_load),
        .err_set  (w_err_set),
        .n_en     (w_n_en),
        .d_en     (w_d_en),
        .k_en     (w_k_en),
        .t_en     (w_t_en),
        .rem_en   (w_rem_en),
        .sel_a    (w_sel_a),
        .sel_b    (w_sel_b)
    );

    always_comb begin
        case (w_sel_a)
            A_D:     w_a = r_d;
            A_K:     w_a = r_k;
            default: w_a = r_n;
        endcase
        case (w_sel_b)
            B_T:     w_b = r_t;
            B_DEN:   w_b = r_den;
            B_N:     w_b = r_n;
            default: w_b = r_k;
        endcase
    end

    // Q2 x Q2 gives Q4; keep the Q2 window and saturate anything >= 4.0.
    assign w_prod = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};
    assign {w_prod_top, w_res_raw, w_prod_unused} = w_prod;
    assign w_res       = (|w_prod_top) ? {WIDTH{1'b1}} : w_res_raw;
    assign w_sqrt_diff = THREE - w_res;
    assign w_k_next    = (r_op == GS_SQRT) ? (w_sqrt_diff >> 1) : (TWO - w_res);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num      <= '0;
            r_den      <= '0;
            r_n        <= '0;
            r_d        <= '0;
            r_k        <= '0;
            r_t        <= '0;
            r_op       <= GS_DIV;
            r_quotient <= '0;
            r_done     <= 1'b0;
            r_rem_sign <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_err_set | w_rem_en;
            if (w_load) begin
                r_num <= bus.numerator;
                r_den <= bus.denominator;
                r_op  <= bus.op;
                r_n   <= bus.numerator;
                r_d   <= (bus.op == GS_SQRT) ? bus.numerator : bus.denominator;
                r_k   <= (bus.op == GS_SQRT) ? K0_SQRT : K0_DIV;
            end
            if (w_n_en) begin
                r_n <= w_res;
            end
            if (w_t_en) begin
                r_t <= w_res;
            end
            if (w_d_en) begin
                r_d <= w_res;
            end
            if (w_k_en) begin
                r_k <= w_k_next;
            end
            // The REM product is QD; results are published on entry to FIN.
            if (w_rem_en) begin
                r_quotient <= r_n;
                r_rem_sign <= (w_res > r_num);
                r_err      <= 1'b0;
            end
            if (w_err_set) begin
                r_quotient <= {WIDTH{1'b1}};
                r_rem_sign <= 1'b0;
                r_err      <= 1'b1;
            end
        end
    end

    assign bus.ready    = w_ready;
    assign bus.done     = r_done;
    assign bus.quotient = r_quotient;
    assign bus.rem_sign = r_rem_sign;
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_goldschmidt_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_goldschmidt_unit
// Description : Directed self-checking bench for a 30-bit/4-iteration and a
//               16-bit/1-iteration Goldschmidt engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_goldschmidt_unit;
    import gs_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    goldschmidt_unit_if #(.WIDTH(30)) bus30();
    goldschmidt_unit_if #(.WIDTH(16)) bus16();

    goldschmidt_unit #(.WIDTH(30), .ITERS(4)) dut30 (.clk(clk), .reset(reset), .bus(bus30));
    goldschmidt_unit #(.WIDTH(16), .ITERS(1)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    task automatic drive30(input gs_op_t op, input logic [29:0] num, input logic [29:0] den);
        @(negedge clk);
        bus30.start = 1'b1; bus30.op = op; bus30.numerator = num; bus30.denominator = den;
        @(posedge clk);
        #1 bus30.start = 1'b0;
    endtask

    task automatic drive16(input gs_op_t op, input logic [15:0] num, input logic [15:0] den);
        @(negedge clk);
        bus16.start = 1'b1; bus16.op = op; bus16.numerator = num; bus16.denominator = den;
        @(posedge clk);
        #1 bus16.start = 1'b0;
    endtask

    // Latency counted in cycles after the accepting edge; -1 on timeout.
    task automatic wait_done30(input int max_cycles, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clk);
            if (bus30.done) begin lat = i; break; end
        end
    endtask

    task automatic wait_done16(input int max_cycles, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clk);
            if (bus16.done) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus30.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus30.ready); end
        checks++; if (bus30.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus30.done); end
        checks++; if (bus30.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus30.err); end
        checks++; if (bus30.rem_sign !== 1'b0) begin failures++; $display("FAIL reset_rem_sign got=%b want=0", bus30.rem_sign); end
        checks++; if (bus30.quotient !== 30'h0) begin failures++; $display("FAIL reset_quotient got=%h want=0", bus30.quotient); end
        checks++; if (bus16.ready !== 1'b1 || bus16.quotient !== 16'h0) begin failures++; $display("FAIL reset16 got ready=%b q=%h want ready=1 q=0", bus16.ready, bus16.quotient); end
    endtask

    task automatic test_divide();
        int lat;
        // 1.5 / 1.0: D=1 gives product of K's = 1 - 2^-16 exactly.
        drive30(GS_DIV, 30'h1800_0000, 30'h1000_0000);
        checks++; if (bus30.ready !== 1'b0) begin failures++; $display("FAIL div_ready_drop got=%b want=0", bus30.ready); end
        wait_done30(40, lat);
        checks++; if (lat != 10) begin failures++; $display("FAIL div15_latency got=%0d want=10", lat); end
        checks++; if (bus30.quotient !== 30'h17FF_E800) begin failures++; $display("FAIL div15_quotient got=%h want=17ffe800", bus30.quotient); end
        checks++; if (bus30.err !== 1'b0 || bus30.rem_sign !== 1'b0) begin failures++; $display("FAIL div15_flags got err=%b rs=%b want 0 0", bus30.err, bus30.rem_sign); end
        checks++; if (bus30.ready !== 1'b1) begin failures++; $display("FAIL div15_ready_fin got=%b want=1", bus30.ready); end
        repeat (3) @(negedge clk);
        checks++; if (bus30.done !== 1'b0 || bus30.quotient !== 30'h17FF_E800) begin failures++; $display("FAIL div15_hold got done=%b q=%h want 0 17ffe800", bus30.done, bus30.quotient); end
        // 1.5 / 1.5: D walks 1.125, 1-2^-6, 1-2^-12, 1-2^-24 and N equals D.
        drive30(GS_DIV, 30'h1800_0000, 30'h1800_0000);
        wait_done30(40, lat);
        checks++; if (lat != 10 || bus30.quotient !== 30'h0FFF_FFF0) begin failures++; $display("FAIL div_equal got lat=%0d q=%h want 10 0ffffff0", lat, bus30.quotient); end
        // 1.0 / 1.0 boundary: 1 - 2^-16.
        drive30(GS_DIV, 30'h1000_0000, 30'h1000_0000);
        wait_done30(40, lat);
        checks++; if (lat != 10 || bus30.quotient !== 30'h0FFF_F000) begin failures++; $display("FAIL div_one got lat=%0d q=%h want 10 0ffff000", lat, bus30.quotient); end
    endtask

    task automatic test_sqrt();
        int lat;
        logic [59:0] sq;
        logic        exp_rs;
        // sqrt(1.5625) = 1.25; denominator is ignored for sqrt, so drive it out of range.
        drive30(GS_SQRT, 30'h1900_0000, 30'h0000_0000);
        wait_done30(40, lat);
        checks++; if (lat != 14) begin failures++; $display("FAIL sqrt_latency got=%0d want=14", lat); end
        // Residual after 4 iterations is about 2.5 ulp below 1.25, plus truncation.
        checks++; if (bus30.quotient < 30'h13FF_FFF0 || bus30.quotient > 30'h1400_0001) begin failures++; $display("FAIL sqrt_quotient got=%h want 13fffff0..14000001", bus30.quotient); end
        checks++; if (bus30.err !== 1'b0) begin failures++; $display("FAIL sqrt_err got=%b want=0", bus30.err); end
        sq     = 60'(bus30.quotient) * 60'(bus30.quotient);
        exp_rs = (sq[57:28] > 30'h1900_0000);
        checks++; if (bus30.rem_sign !== exp_rs) begin failures++; $display("FAIL sqrt_rem_sign got=%b want=%b", bus30.rem_sign, exp_rs); end
    endtask

    task automatic test_range_error();
        int lat;
        drive30(GS_DIV, 30'h1800_0000, 30'h0800_0000);
        wait_done30(5, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL err_den_latency got=%0d want=1", lat); end
        checks++; if (bus30.err !== 1'b1 || bus30.quotient !== 30'h3FFF_FFFF || bus30.rem_sign !== 1'b0) begin failures++; $display("FAIL err_den_out got err=%b q=%h rs=%b want 1 3fffffff 0", bus30.err, bus30.quotient, bus30.rem_sign); end
        checks++; if (bus30.ready !== 1'b1) begin failures++; $display("FAIL err_ready got=%b want=1", bus30.ready); end
        drive30(GS_SQRT, 30'h2000_0000, 30'h1000_0000);
        wait_done30(5, lat);
        checks++; if (lat != 1 || bus30.err !== 1'b1) begin failures++; $display("FAIL err_sqrt_num got lat=%0d err=%b want 1 1", lat, bus30.err); end
        drive30(GS_DIV, 30'h0FFF_FFFF, 30'h1000_0000);
        wait_done30(5, lat);
        checks++; if (lat != 1 || bus30.err !== 1'b1) begin failures++; $display("FAIL err_num_below_one got lat=%0d err=%b want 1 1", lat, bus30.err); end
        drive30(GS_DIV, 30'h1800_0000, 30'h1800_0000);
        wait_done30(40, lat);
        checks++; if (lat != 10 || bus30.err !== 1'b0 || bus30.quotient !== 30'h0FFF_FFF0) begin failures++; $display("FAIL err_clear got lat=%0d err=%b q=%h want 10 0 0ffffff0", lat, bus30.err, bus30.quotient); end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int first  = -1;
        int second = -1;
        @(negedge clk);
        bus30.start = 1'b1; bus30.op = GS_DIV; bus30.numerator = 30'h1800_0000; bus30.denominator = 30'h1000_0000;
        @(posedge clk);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (bus30.done) begin
                n_done++;
                if (first < 0) first = c; else if (second < 0) second = c;
            end
            if (c == 5) begin
                checks++; if (bus30.ready !== 1'b0) begin failures++; $display("FAIL b2b_busy_ready got=%b want=0", bus30.ready); end
            end
            if (c == 20) bus30.start = 1'b0;
        end
        checks++; if (n_done != 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", n_done); end
        checks++; if (first != 10 || second != 20) begin failures++; $display("FAIL b2b_done_cycles got=%0d,%0d want=10,20", first, second); end
        checks++; if (bus30.quotient !== 30'h17FF_E800) begin failures++; $display("FAIL b2b_quotient got=%h want=17ffe800", bus30.quotient); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int n_done = 0;
        drive30(GS_DIV, 30'h1800_0000, 30'h1000_0000);
        repeat (4) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (bus30.ready !== 1'b1 || bus30.quotient !== 30'h0 || bus30.done !== 1'b0) begin failures++; $display("FAIL midreset_state got ready=%b q=%h done=%b want 1 0 0", bus30.ready, bus30.quotient, bus30.done); end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus30.done) n_done++;
        end
        checks++; if (n_done != 0) begin failures++; $display("FAIL midreset_no_done got=%0d want=0", n_done); end
        drive30(GS_DIV, 30'h1800_0000, 30'h1800_0000);
        wait_done30(40, lat);
        checks++; if (lat != 10 || bus30.quotient !== 30'h0FFF_FFF0) begin failures++; $display("FAIL midreset_fresh got lat=%0d q=%h want 10 0ffffff0", lat, bus30.quotient); end
    endtask

    task automatic test_small_build();
        int lat;
        // One iteration: N = 1.0 * 0.75.
        drive16(GS_DIV, 16'h4000, 16'h4000);
        wait_done16(20, lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL w16_div_latency got=%0d want=4", lat); end
        checks++; if (bus16.quotient !== 16'h3000 || bus16.err !== 1'b0 || bus16.rem_sign !== 1'b0) begin failures++; $display("FAIL w16_div_out got q=%h err=%b rs=%b want 3000 0 0", bus16.quotient, bus16.err, bus16.rem_sign); end
        // N = 1.0 * K0_SQRT, round(0.8535534 * 2^14) = 13985.
        drive16(GS_SQRT, 16'h4000, 16'h0000);
        wait_done16(20, lat);
        checks++; if (lat != 5) begin failures++; $display("FAIL w16_sqrt_latency got=%0d want=5", lat); end
        checks++; if (bus16.quotient !== 16'h36A1 || bus16.rem_sign !== 1'b0) begin failures++; $display("FAIL w16_sqrt_out got q=%h rs=%b want 36a1 0", bus16.quotient, bus16.rem_sign); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus30.start = 1'b0; bus30.op = GS_DIV; bus30.numerator = '0; bus30.denominator = '0;
        bus16.start = 1'b0; bus16.op = GS_DIV; bus16.numerator = '0; bus16.denominator = '0;
        test_reset();
        test_divide();
        test_sqrt();
        test_range_error();
        test_back_to_back();
        test_reset_mid_op();
        test_small_build();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
